// File: rtl/hd_pair_sched_pkg.sv
// hd_pair_sched_pkg: shared constants and types for the Hamming(7,4) pair scheduler.
//   - Codeword bit positions, {p1,p2,p3,x1,x2,x3,x4} = b6..b0
//   - Syndrome codes, s = {A,B,C}
//   - Channel ID, codeword and 6-bit signed result types
//   - hd_decode(): single-codeword syndrome decode and correction
package hd_pair_sched_pkg;

    localparam int NUM_CH = 2;
    localparam int CW_W   = 7;
    localparam int RES_W  = 6;

    localparam logic [2:0] B_X4 = 3'd0;
    localparam logic [2:0] B_X3 = 3'd1;
    localparam logic [2:0] B_X2 = 3'd2;
    localparam logic [2:0] B_X1 = 3'd3;
    localparam logic [2:0] B_P3 = 3'd4;
    localparam logic [2:0] B_P2 = 3'd5;
    localparam logic [2:0] B_P1 = 3'd6;

    localparam logic [2:0] SYN_NONE = 3'b000;
    localparam logic [2:0] SYN_X1   = 3'b111;
    localparam logic [2:0] SYN_X4   = 3'b110;
    localparam logic [2:0] SYN_X3   = 3'b101;
    localparam logic [2:0] SYN_X2   = 3'b011;
    localparam logic [2:0] SYN_P3   = 3'b100;
    localparam logic [2:0] SYN_P2   = 3'b010;
    localparam logic [2:0] SYN_P1   = 3'b001;

    typedef logic                    ch_id_t;
    typedef logic [CW_W-1:0]         cw_t;
    typedef logic signed [RES_W-1:0] res_t;

    typedef struct packed {
        logic [3:0] c;   // corrected data {x1,x2,x3,x4}, two's complement
        logic       e;   // received value of the syndrome-selected bit
        logic       nz;  // syndrome nonzero
    } dec_t;

    function automatic dec_t hd_decode(input cw_t cw);
        logic [2:0] syn;
        logic [2:0] sel;
        cw_t        fixed;
        dec_t       d;
        syn = {cw[4] ^ cw[3] ^ cw[1] ^ cw[0],
               cw[5] ^ cw[3] ^ cw[2] ^ cw[0],
               cw[6] ^ cw[3] ^ cw[2] ^ cw[1]};
        case (syn)
            SYN_X1:  sel = B_X1;
            SYN_X4:  sel = B_X4;
            SYN_X3:  sel = B_X3;
            SYN_X2:  sel = B_X2;
            SYN_P3:  sel = B_P3;
            SYN_P2:  sel = B_P2;
            SYN_P1:  sel = B_P1;
            default: sel = B_P3;  // clean word: error bit is read from p3
        endcase
        fixed = cw;
        if (syn != SYN_NONE)
            fixed[sel] = ~cw[sel];
        d.c  = fixed[3:0];
        d.e  = cw[sel];
        d.nz = (syn != SYN_NONE);
        return d;
    endfunction

endpackage

// File: rtl/hd_pair_sched_if.sv
// hd_pair_sched_if: request/result bundle for hd_pair_sched.
//   req0_* / req1_*  : per-channel valid/ready + two 7-bit codewords
//   out_*            : result valid/ready, requester ID, signed 6-bit result
//   err_cnt0/1       : per-channel corrected-codeword counters (CNT_W bits)
// modport slave is the scheduler side, modport master the requester/sink side.
interface hd_pair_sched_if #(parameter int CNT_W = 16);

    logic              req0_valid, req0_ready;
    logic [6:0]        req0_cw1,   req0_cw2;
    logic              req1_valid, req1_ready;
    logic [6:0]        req1_cw1,   req1_cw2;
    logic              out_valid,  out_ready;
    logic              out_id;
    logic signed [5:0] out_n;
    logic [CNT_W-1:0]  err_cnt0,   err_cnt1;

    modport master (
        output req0_valid, req0_cw1, req0_cw2,
        output req1_valid, req1_cw1, req1_cw2,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_id, out_n, err_cnt0, err_cnt1
    );

    modport slave (
        input  req0_valid, req0_cw1, req0_cw2,
        input  req1_valid, req1_cw1, req1_cw2,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_id, out_n, err_cnt0, err_cnt1
    );

endinterface

// File: rtl/hd_pair_sched_core.sv
// hd_pair_core: combinational Hamming(7,4) pair decode and combine.
//   cw1, cw2 : received codewords
//   out_n    : signed 6-bit combined result (range -24..23, never overflows)
//   nz1, nz2 : syndrome of cw1 / cw2 nonzero
module hd_pair_core
    import hd_pair_sched_pkg::*;
(
    input  cw_t  cw1,
    input  cw_t  cw2,
    output res_t out_n,
    output logic nz1,
    output logic nz2
);

    dec_t d1, d2;
    res_t c1, c2, w1, w2;

    always_comb begin
        d1    = hd_decode(cw1);
        d2    = hd_decode(cw2);
        c1    = {{2{d1.c[3]}}, d1.c};
        c2    = {{2{d2.c[3]}}, d2.c};
        // e1 picks which operand gets doubled; e1^e2 picks add vs subtract
        w1    = d1.e ? c1 : (c1 <<< 1);
        w2    = d1.e ? (c2 <<< 1) : c2;
        out_n = (d1.e ^ d2.e) ? (w1 - w2) : (w1 + w2);
        nz1   = d1.nz;
        nz2   = d2.nz;
    end

endmodule

// File: rtl/hd_pair_sched.sv
// hd_pair_sched: two-requester scheduler sharing one Hamming(7,4) pair decoder.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : hd_pair_sched_if.slave (requests, result stream, error counters)
// Pipeline: arbiter -> S1 {vld,id,cw1,cw2} -> hd_pair_core -> S2/output register.
// PRIO_FIXED=0 round-robin on ties, 1 = channel 0 always wins ties.
// Optional feature: define HD_ERR_STATS_EN to build the saturating per-channel
// corrected-codeword counters; otherwise err_cnt0/1 read 0 and have no flops.
module hd_pair_sched
    import hd_pair_sched_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int PRIO_FIXED = 0
) (
    input logic            clk,
    input logic            rst,
    hd_pair_sched_if.slave bus
);

    logic   [NUM_CH-1:0] req_valid, grant;
    cw_t                 req_cw1 [NUM_CH];
    cw_t                 req_cw2 [NUM_CH];

    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign req_cw1[0] = bus.req0_cw1;
    assign req_cw1[1] = bus.req1_cw1;
    assign req_cw2[0] = bus.req0_cw2;
    assign req_cw2[1] = bus.req1_cw2;

    logic   s1_vld;
    ch_id_t s1_id;
    cw_t    s1_cw1, s1_cw2;
    logic   out_valid_q;
    ch_id_t out_id_q;
    res_t   out_n_q;
    ch_id_t last_id;

    logic   s2_load, s1_xfer, s1_accept, any_valid;
    res_t   core_n;
    logic   nz1, nz2;

    assign s2_load   = !out_valid_q || bus.out_ready;
    assign s1_xfer   = s1_vld && s2_load;
    assign s1_accept = !s1_vld || s2_load;
    assign any_valid = |req_valid;

    // Tie goes to whoever was not granted last; last_id resets to 1 so ch0 wins first.
    always_comb begin
        grant    = '0;
        grant[0] = req_valid[0] && (!req_valid[1] || (PRIO_FIXED != 0) || (last_id == 1'b1));
        grant[1] = req_valid[1] && !grant[0];
    end

    assign bus.req0_ready = grant[0] && s1_accept;
    assign bus.req1_ready = grant[1] && s1_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_id   <= 1'b0;
            s1_cw1  <= '0;
            s1_cw2  <= '0;
            last_id <= 1'b1;
        end else if (s1_accept) begin
            s1_vld <= any_valid;
            if (any_valid) begin
                s1_id   <= grant[1];
                s1_cw1  <= grant[1] ? req_cw1[1] : req_cw1[0];
                s1_cw2  <= grant[1] ? req_cw2[1] : req_cw2[0];
                last_id <= grant[1];
            end
        end
    end

    hd_pair_core u_core (
        .cw1   (s1_cw1),
        .cw2   (s1_cw2),
        .out_n (core_n),
        .nz1   (nz1),
        .nz2   (nz2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_n_q     <= '0;
        end else if (s2_load) begin
            out_valid_q <= s1_vld;
            if (s1_vld) begin
                out_id_q <= s1_id;
                out_n_q  <= core_n;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_n     = out_n_q;

    logic [NUM_CH-1:0][CNT_W-1:0] err_cnt;

`ifdef HD_ERR_STATS_EN
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_cnt
        logic [CNT_W:0] sum;
        assign sum = {1'b0, err_cnt[ch]} + (CNT_W+1)'(nz1) + (CNT_W+1)'(nz2);
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                err_cnt[ch] <= '0;
            else if (s1_xfer && (s1_id == ch_id_t'(ch)))
                err_cnt[ch] <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{nz1, nz2, s1_xfer};
    assign err_cnt      = '0;
`endif

    assign bus.err_cnt0 = err_cnt[0];
    assign bus.err_cnt1 = err_cnt[1];

endmodule

// File: tb/tb_hd_pair_sched.sv
module tb_hd_pair_sched;

    localparam int CNT_W = 16;
    localparam int PRIO  = 0;
    localparam logic [6:0] MASK_A = 7'b0011011;
    localparam logic [6:0] MASK_B = 7'b0101101;
    localparam logic [6:0] MASK_C = 7'b1001110;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hd_pair_sched_if #(.CNT_W(CNT_W)) bus ();
    hd_pair_sched #(.CNT_W(CNT_W), .PRIO_FIXED(PRIO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit even_all(input logic [6:0] w);
        return ($countones(w & MASK_A) % 2 == 0) && ($countones(w & MASK_B) % 2 == 0) &&
               ($countones(w & MASK_C) % 2 == 0);
    endfunction

    // Locate the error by finding the single flip that makes every group even.
    function automatic void m_dec(input logic [6:0] cw, output int c, output bit e, output bit nz);
        int k;
        logic [6:0] fixed;
        k = 4;
        fixed = cw;
        nz = !even_all(cw);
        if (nz) begin
            for (int i = 0; i < 7; i++)
                if (even_all(cw ^ (7'd1 << i))) k = i;
            fixed = cw ^ (7'd1 << k);
        end
        e = cw[k];
        c = int'(fixed[3:0]);
        if (c > 7) c -= 16;
    endfunction

    function automatic int m_pair(input logic [6:0] cw1, input logic [6:0] cw2, output int nzs);
        int c1, c2, w1, w2;
        bit e1, e2, z1, z2;
        m_dec(cw1, c1, e1, z1);
        m_dec(cw2, c2, e2, z2);
        nzs = int'(z1) + int'(z2);
        w1 = e1 ? c1 : 2 * c1;
        w2 = e1 ? 2 * c2 : c2;
        return (e1 != e2) ? w1 - w2 : w1 + w2;
    endfunction

    int cnt_exp[2];
    function automatic int exp_cnt(input int ch);
`ifdef HD_ERR_STATS_EN
        return cnt_exp[ch];
`else
        return 0 * ch;
`endif
    endfunction

    task automatic chk_cnts(input string tag);
        chk({tag, ".err_cnt0"}, int'(bus.err_cnt0), exp_cnt(0));
        chk({tag, ".err_cnt1"}, int'(bus.err_cnt1), exp_cnt(1));
    endtask

    task automatic drive(input bit v0, input logic [6:0] a0, input logic [6:0] b0,
                         input bit v1, input logic [6:0] a1, input logic [6:0] b1);
        bus.req0_valid = v0; bus.req0_cw1 = a0; bus.req0_cw2 = b0;
        bus.req1_valid = v1; bus.req1_cw1 = a1; bus.req1_cw2 = b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        cnt_exp[0] = 0;
        cnt_exp[1] = 0;
    endtask

    typedef struct {
        bit         id;
        logic [6:0] cw1;
        logic [6:0] cw2;
        int         exp_n;
        int         exp_nz;
    } vec_t;
    vec_t tbl[9];

    typedef struct {
        bit id;
        int n;
    } exp_t;
    exp_t q[$];

    int ids[$];
    int ns[$];

    initial begin
        tbl[0] = '{0, 7'h46, 7'h54,   1, 2};
        tbl[1] = '{1, 7'h57, 7'h54,  -5, 2};
        tbl[2] = '{0, 7'h55, 7'h55,  15, 0};
        tbl[3] = '{1, 7'h00, 7'h00,   0, 0};
        tbl[4] = '{0, 7'h7F, 7'h7F,  -3, 0};
        tbl[5] = '{1, 7'h78, 7'h78, -24, 0};
        tbl[6] = '{0, 7'h07, 7'h07,  21, 0};
        tbl[7] = '{1, 7'h07, 7'h55,   9, 0};
        tbl[8] = '{0, 7'h15, 7'h07,  17, 1};

        // ---- reset state ----
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1;
        step();
        chk("rst.out_valid", int'(bus.out_valid), 0);
        chk("rst.out_id", int'(bus.out_id), 0);
        chk("rst.out_n", int'($signed(bus.out_n)), 0);
        cnt_exp[0] = 0;
        cnt_exp[1] = 0;
        chk_cnts("rst");
        step();
        rst = 1'b0;

        // ---- table: single-channel pairs, latency and value ----
        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            if (tbl[i].id) drive(0, 0, 0, 1, tbl[i].cw1, tbl[i].cw2);
            else           drive(1, tbl[i].cw1, tbl[i].cw2, 0, 0, 0);
            @(negedge clk);
            chk({t, ".ready"}, int'(tbl[i].id ? bus.req1_ready : bus.req0_ready), 1);
            chk({t, ".other_ready"}, int'(tbl[i].id ? bus.req0_ready : bus.req1_ready), 0);
            step();
            drive(0, 0, 0, 0, 0, 0);
            chk({t, ".lat1_valid"}, int'(bus.out_valid), 0);
            step();
            chk({t, ".lat2_valid"}, int'(bus.out_valid), 1);
            chk({t, ".out_id"}, int'(bus.out_id), int'(tbl[i].id));
            chk({t, ".out_n"}, int'($signed(bus.out_n)), tbl[i].exp_n);
            cnt_exp[tbl[i].id] += tbl[i].exp_nz;
            chk_cnts(t);
        end
        step();
        chk("drain.out_valid", int'(bus.out_valid), 0);

        // ---- both valid every cycle: round-robin alternation ----
        do_reset();
        drive(1, 7'h46, 7'h54, 1, 7'h57, 7'h54);
        ids.delete();
        ns.delete();
        for (int c = 0; c < 9; c++) begin
            if (c == 6) drive(0, 0, 0, 0, 0, 0);
            step();
            if (bus.out_valid) begin
                ids.push_back(int'(bus.out_id));
                ns.push_back(int'($signed(bus.out_n)));
            end
        end
        chk("rr.count", ids.size(), 6);
        for (int k = 0; k < ids.size() && k < 6; k++) begin
            int eid;
            eid = (PRIO != 0) ? 0 : (k % 2);
            chk($sformatf("rr.id%0d", k), ids[k], eid);
            chk($sformatf("rr.n%0d", k), ns[k], (eid == 0) ? 1 : -5);
        end

        // ---- backpressure: S2 holds, one more pair fills S1, then ready drops ----
        do_reset();
        bus.out_ready = 1'b0;
        drive(1, 7'h46, 7'h54, 1, 7'h57, 7'h54);
        step();
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d.valid", c), int'(bus.out_valid), 1);
            chk($sformatf("stall%0d.id", c), int'(bus.out_id), 0);
            chk($sformatf("stall%0d.n", c), int'($signed(bus.out_n)), 1);
            chk($sformatf("stall%0d.rdy", c), int'(bus.req0_ready | bus.req1_ready), 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1;
        step();
        chk("release.valid", int'(bus.out_valid), 1);
        chk("release.id", int'(bus.out_id), 1);
        chk("release.n", int'($signed(bus.out_n)), -5);
        step();
        chk("release.empty", int'(bus.out_valid), 0);

        // ---- async reset with S1 and S2 full ----
        bus.out_ready = 1'b0;
        drive(1, 7'h57, 7'h54, 1, 7'h46, 7'h54);
        step();
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst.out_valid", int'(bus.out_valid), 0);
        chk("arst.out_id", int'(bus.out_id), 0);
        chk("arst.out_n", int'($signed(bus.out_n)), 0);
        cnt_exp[0] = 0;
        cnt_exp[1] = 0;
        chk_cnts("arst");
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("arst.first_grant0", int'(bus.req0_ready), 1);
        chk("arst.first_grant1", int'(bus.req1_ready), 0);
        drive(0, 0, 0, 0, 0, 0);

        // ---- randomized traffic vs. reference model ----
        do_reset();
        begin
            bit v[2];
            logic [6:0] a[2], b[2];
            int last;
            last = 1;
            q.delete();
            v[0] = 0; v[1] = 0;
            for (int c = 0; c < 600; c++) begin
                bit acc, r0, r1, g0, g1, ord;
                for (int ch = 0; ch < 2; ch++)
                    if (!v[ch]) begin
                        v[ch] = ($urandom % 4) != 0;
                        a[ch] = 7'($urandom);
                        b[ch] = 7'($urandom);
                    end
                drive(v[0], a[0], b[0], v[1], a[1], b[1]);
                ord = ($urandom % 4) != 0;
                bus.out_ready = ord;
                @(negedge clk);
                acc = (q.size() < 2) || ord;
                g0 = v[0] && (!v[1] || (PRIO != 0) || last == 1);
                g1 = v[1] && !g0;
                r0 = acc && g0;
                r1 = acc && g1;
                chk("rnd.req0_ready", int'(bus.req0_ready), int'(r0));
                chk("rnd.req1_ready", int'(bus.req1_ready), int'(r1));
                if (bus.out_valid && ord) begin
                    if (q.size() == 0) begin
                        chk("rnd.unexpected_out", 1, 0);
                    end else begin
                        exp_t x;
                        x = q.pop_front();
                        chk("rnd.out_id", int'(bus.out_id), int'(x.id));
                        chk("rnd.out_n", int'($signed(bus.out_n)), x.n);
                    end
                end
                if (r0 || r1) begin
                    exp_t x;
                    int nzs, ch;
                    ch = r1 ? 1 : 0;
                    x.id = r1;
                    x.n = m_pair(a[ch], b[ch], nzs);
                    q.push_back(x);
                    cnt_exp[ch] += nzs;
                    last = ch;
                    v[ch] = 0;
                end
                step();
            end
            drive(0, 0, 0, 0, 0, 0);
            bus.out_ready = 1'b1;
            for (int c = 0; c < 10 && q.size() != 0; c++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    exp_t x;
                    x = q.pop_front();
                    chk("drain.out_id", int'(bus.out_id), int'(x.id));
                    chk("drain.out_n", int'($signed(bus.out_n)), x.n);
                end
                step();
            end
            chk("drain.left", q.size(), 0);
            chk_cnts("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
